// File: rtl/matmul_tile_scheduler_if.sv
// Host/controller-facing signal bundle of the tile scheduler.
// The slave modport is the scheduler's view; master is the host/controller side.
interface matmul_tile_scheduler_if #(
    parameter int W_SIZE = 256,
    parameter int I_SIZE = 256,
    parameter int O_SIZE = 256,
    parameter int CNT_W  = 8
);
    localparam int WA = $clog2(W_SIZE);
    localparam int IA = $clog2(I_SIZE);
    localparam int OA = $clog2(O_SIZE);

    logic             start_i;
    logic             abort_i;
    logic [CNT_W-1:0] n_wt_i;
    logic [CNT_W-1:0] n_it_i;
    logic [WA-1:0]    w_base_i;
    logic [WA-1:0]    w_stride_i;
    logic [IA-1:0]    i_base_i;
    logic [IA-1:0]    i_stride_i;
    logic [OA-1:0]    o_base_i;
    logic [OA-1:0]    o_stride_i;
    logic             mm_start_o;
    logic [WA-1:0]    mm_w_offset_o;
    logic [IA-1:0]    mm_i_offset_o;
    logic [OA-1:0]    mm_o_offset_o;
    logic             mm_done_i;
    logic [CNT_W-1:0] wt_idx_o;
    logic [CNT_W-1:0] it_idx_o;
    logic             busy_o;
    logic             done_o;
    logic             aborted_o;

    modport master (
        output start_i, abort_i, n_wt_i, n_it_i, w_base_i, w_stride_i,
               i_base_i, i_stride_i, o_base_i, o_stride_i, mm_done_i,
        input  mm_start_o, mm_w_offset_o, mm_i_offset_o, mm_o_offset_o,
               wt_idx_o, it_idx_o, busy_o, done_o, aborted_o
    );

    modport slave (
        input  start_i, abort_i, n_wt_i, n_it_i, w_base_i, w_stride_i,
               i_base_i, i_stride_i, o_base_i, o_stride_i, mm_done_i,
        output mm_start_o, mm_w_offset_o, mm_i_offset_o, mm_o_offset_o,
               wt_idx_o, it_idx_o, busy_o, done_o, aborted_o
    );
endinterface

// File: rtl/matmul_tile_scheduler.sv
// Walks a weight-tile (outer) x input-tile (inner) grid, issuing one controller run per tile
// with the matching buffer offsets and waiting for each run's done edge.
module matmul_tile_scheduler #(
    parameter int W_SIZE = 256,
    parameter int I_SIZE = 256,
    parameter int O_SIZE = 256,
    parameter int CNT_W  = 8
) (
    input logic                    clk_i,
    input logic                    rst_i,
    matmul_tile_scheduler_if.slave bus
);
    localparam int WA = $clog2(W_SIZE);
    localparam int IA = $clog2(I_SIZE);
    localparam int OA = $clog2(O_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wt_q, wt_d, it_q, it_d;
    logic [CNT_W-1:0] n_wt_q, n_wt_d, n_it_q, n_it_d;
    logic [WA-1:0]    w_off_q, w_off_d, w_stride_q, w_stride_d;
    logic [IA-1:0]    i_off_q, i_off_d, i_base_q, i_base_d, i_stride_q, i_stride_d;
    logic [OA-1:0]    o_off_q, o_off_d, o_stride_q, o_stride_d;
    logic             mm_start_q, mm_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             abort_q, abort_d;
    logic             start_q, arm_q, ctl_done_q;
    logic             start_rise, ctl_done_rise, last_it, last_tile;

    // arm_q blanks the first cycle after reset so a start level held through reset is not a new edge.
    assign start_rise    = bus.start_i & ~start_q & arm_q;
    assign ctl_done_rise = bus.mm_done_i & ~ctl_done_q;
    assign last_it       = (it_q == n_it_q - CNT_W'(1));
    assign last_tile     = last_it && (wt_q == n_wt_q - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        wt_d       = wt_q;
        it_d       = it_q;
        n_wt_d     = n_wt_q;
        n_it_d     = n_it_q;
        w_off_d    = w_off_q;
        w_stride_d = w_stride_q;
        i_off_d    = i_off_q;
        i_base_d   = i_base_q;
        i_stride_d = i_stride_q;
        o_off_d    = o_off_q;
        o_stride_d = o_stride_q;
        mm_start_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        aborted_d  = aborted_q;
        abort_d    = abort_q;

        if (state_q != S_IDLE && bus.abort_i) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    n_wt_d     = bus.n_wt_i;
                    n_it_d     = bus.n_it_i;
                    w_stride_d = bus.w_stride_i;
                    i_base_d   = bus.i_base_i;
                    i_stride_d = bus.i_stride_i;
                    o_stride_d = bus.o_stride_i;
                    wt_d       = '0;
                    it_d       = '0;
                    w_off_d    = bus.w_base_i;
                    i_off_d    = bus.i_base_i;
                    o_off_d    = bus.o_base_i;
                    aborted_d  = 1'b0;
                    abort_d    = 1'b0;
                    busy_d     = 1'b1;
                    if (bus.n_wt_i == '0 || bus.n_it_i == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mm_start_d = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (ctl_done_rise) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (abort_q || last_tile) begin
                    state_d = S_FIN;
                end else begin
                    if (!last_it) begin
                        it_d    = it_q + CNT_W'(1);
                        i_off_d = i_off_q + i_stride_q;
                    end else begin
                        it_d    = '0;
                        i_off_d = i_base_q;
                        wt_d    = wt_q + CNT_W'(1);
                        w_off_d = w_off_q + w_stride_q;
                    end
                    // Outputs land row-major: one output slot per issued tile.
                    o_off_d = o_off_q + o_stride_q;
                    state_d = S_ISSUE;
                end
            end
            S_FIN: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                aborted_d = abort_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wt_q       <= '0;
            it_q       <= '0;
            w_off_q    <= '0;
            i_off_q    <= '0;
            o_off_q    <= '0;
            mm_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            abort_q    <= 1'b0;
            start_q    <= 1'b0;
            arm_q      <= 1'b0;
            ctl_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wt_q       <= wt_d;
            it_q       <= it_d;
            w_off_q    <= w_off_d;
            i_off_q    <= i_off_d;
            o_off_q    <= o_off_d;
            mm_start_q <= mm_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            abort_q    <= abort_d;
            start_q    <= bus.start_i;
            arm_q      <= 1'b1;
            ctl_done_q <= bus.mm_done_i;
        end
    end

    // Job configuration is only read after acceptance, so it needs no reset.
    always_ff @(posedge clk_i) begin
        n_wt_q     <= n_wt_d;
        n_it_q     <= n_it_d;
        w_stride_q <= w_stride_d;
        i_base_q   <= i_base_d;
        i_stride_q <= i_stride_d;
        o_stride_q <= o_stride_d;
    end

    assign bus.mm_start_o    = mm_start_q;
    assign bus.mm_w_offset_o = w_off_q;
    assign bus.mm_i_offset_o = i_off_q;
    assign bus.mm_o_offset_o = o_off_q;
    assign bus.wt_idx_o      = wt_q;
    assign bus.it_idx_o      = it_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.aborted_o     = aborted_q;
endmodule
